bp_be_dcache_wbuf_queue: RTL
============================

# bp_be_dcache_wbuf_queue

Parametrised, multi-entry store write buffer for the backend data cache. It sits between the dcache store pipeline stage and the data-memory write port. It accepts word-aligned store entries with byte masks and drains them in FIFO order. Stores to the same word as the youngest buffered entry are coalesced into that entry. A combinational byte-granular bypass serves younger loads from buffered data.

## Interface
- data_width_p, 64, store data width in bits; multiple of 8
- paddr_width_p, 22, width of word-aligned store address
- els_p, 4, buffer depth; power of 2, >= 2
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- v_i  in  1  store entry valid
- addr_i  in  paddr_width_p  word address of the store
- data_i  in  data_width_p  store data, already byte-lane aligned
- mask_i  in  data_width_p/8  byte enables; nonzero when v_i
- ready_o  out  1  buffer can accept an entry; equals ~full
- v_o  out  1  head entry valid, i.e. not empty
- addr_o  out  paddr_width_p  head address
- data_o  out  data_width_p  head data
- mask_o  out  data_width_p/8  head mask
- yumi_i  in  1  head consumed this cycle; legal only when v_o
- bypass_v_i  in  1  load lookup valid
- bypass_addr_i  in  paddr_width_p  load word address
- bypass_data_o  out  data_width_p  forwarded bytes; 0 in unmasked lanes
- bypass_mask_o  out  data_width_p/8  lanes supplied by the buffer; 0 when bypass_v_i low
- count_o  out  $clog2(els_p+1)  occupied entries
- empty_o  out  1  count_o == 0

## Operation
- Circular buffer: head pointer and tail pointer, each $clog2(els_p) bits, wrapping modulo els_p, plus an occupancy counter.
- Enqueue condition: v_i & ready_o.
- Coalesce hit: enqueue & count != 0 & addr_i == addr[tail-1], and the youngest entry is not being dequeued this cycle. The youngest entry is being dequeued when yumi_i & count == 1.
  - On hit, for each lane with mask_i set, data[tail-1] lane is replaced and mask[tail-1] lane is set.
  - Tail and count are unchanged.
- Enqueue without a hit writes a new entry at tail and increments tail.
- Dequeue on yumi_i increments head.
- Count update: +1 for a non-coalescing enqueue only, -1 for dequeue only, unchanged when both or neither occur.
- Count never exceeds els_p.
- ready_o = (count != els_p). It does not depend on yumi_i, so a full buffer does not pass through in the same cycle.
- Coalescing into a full buffer is not performed. ready_o is 0 when full regardless of address.
- Bypass:
  - For each byte lane, take the youngest valid entry with addr == bypass_addr_i and that lane's mask bit set.
  - That entry supplies the lane's data byte and asserts the lane's bypass_mask_o bit.
  - Scan is age-ordered from head to tail-1.
  - A same-cycle incoming v_i and a same-cycle dequeued head are both handled on registered state only. The head being yumi'd is still visible to the bypass; the incoming entry is not.
- Assertions:
  - yumi_i & ~v_o is illegal.
  - v_i & mask_i == 0 is illegal.

## Timing
- Reset values:
  - Asynchronously clears head, tail and count.
  - Outputs: ready_o=1, v_o=0, empty_o=1, count_o=0, bypass_mask_o=0, bypass_data_o=0.
  - addr_o, data_o and mask_o are don't-care while v_o=0. The implementation drives them from entry 0 storage, which is not cleared.
- Reset asserted mid-operation discards all entries immediately. There is no drain.
- Enqueue latency: an entry written at edge N is visible on v_o, bypass and count_o from cycle N+1.
- A coalesced update is visible on head outputs and bypass from N+1.
- Dequeue: yumi_i at edge N advances head; the next entry appears at N+1.
- Bypass outputs, v_o, ready_o and head outputs are combinational from registered state. There is no input-to-output combinational path except bypass_addr_i/bypass_v_i to bypass_*.
- Empty with v_i: the entry appears at N+1. There is no fall-through.

## Test plan
- Reset, fill: after reset, enqueue 4 distinct addresses 0x10..0x13, mask 0xFF, with yumi_i=0.
  - Required: count_o=4, ready_o=0 after the fourth, v_o=1, addr_o=0x10.
- Coalesce:
  - Enqueue addr 0x20, data 0x11, mask 0x01; then addr 0x20, data 0x2200, mask 0x02.
  - Required: count_o=1, head data 0x2211, mask 0x03.
  - Repeat with a non-matching store in between. Required: no coalesce, count_o=3.
- Bypass priority:
  - Entries in order: 0x30 mask 0xFF data 0xAA..AA; 0x31; then 0x30 mask 0x0F data 0x...BBBBBBBB.
  - Lookup 0x30. Required: bypass_mask_o=0xFF, low 4 bytes 0xBB, high 4 bytes 0xAA.
  - Lookup 0x40. Required: bypass_mask_o=0.
- Simultaneous enqueue and dequeue, wrap-around:
  - Hold v_i and yumi_i high for 12 cycles with incrementing addresses.
  - Required: count constant, FIFO order preserved across pointer wrap.
- Coalesce race: count=1, head 0x50 being yumi'd, v_i with addr 0x50.
  - Required: no coalesce, new entry allocated, count_o stays 1, next head data equals the new store only.
- Async reset mid-stream: assert reset_i between edges with 3 entries held.
  - Required: v_o=0, count_o=0, ready_o=1 immediately, before the next clock edge.

Source files
------------

// File: rtl/bp_be_dcache_wbuf_queue.sv
// Store write buffer for the backend data cache.
// Accepts word-aligned, byte-masked store entries and drains them in FIFO
// order. A store to the same word as the youngest buffered entry is merged
// into that entry instead of allocating a new slot. A combinational,
// byte-granular bypass returns the youngest buffered byte for each lane of a
// load's word address.
module bp_be_dcache_wbuf_queue #(
  parameter int data_width_p  = 64,
  parameter int paddr_width_p = 22,
  parameter int els_p         = 4,
  localparam int mask_width_lp  = data_width_p / 8,
  localparam int count_width_lp = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic                      v_i,
  input  logic [paddr_width_p-1:0]  addr_i,
  input  logic [data_width_p-1:0]   data_i,
  input  logic [mask_width_lp-1:0]  mask_i,
  output logic                      ready_o,

  output logic                      v_o,
  output logic [paddr_width_p-1:0]  addr_o,
  output logic [data_width_p-1:0]   data_o,
  output logic [mask_width_lp-1:0]  mask_o,
  input  logic                      yumi_i,

  input  logic                      bypass_v_i,
  input  logic [paddr_width_p-1:0]  bypass_addr_i,
  output logic [data_width_p-1:0]   bypass_data_o,
  output logic [mask_width_lp-1:0]  bypass_mask_o,

  output logic [count_width_lp-1:0] count_o,
  output logic                      empty_o
);

  localparam int ptr_width_lp = $clog2(els_p);

  // Entry storage; deliberately not reset, validity is tracked by count_r
  logic [paddr_width_p-1:0] addr_mem [els_p];
  logic [data_width_p-1:0]  data_mem [els_p];
  logic [mask_width_lp-1:0] mask_mem [els_p];

  logic [ptr_width_lp-1:0]   head_r;
  logic [ptr_width_lp-1:0]   tail_r;
  logic [ptr_width_lp-1:0]   tail_prev;
  logic [count_width_lp-1:0] count_r;

  logic full;
  logic empty;
  logic enq;
  logic deq;
  logic youngest_deq;
  logic hit;
  logic alloc;

  assign full  = (count_r == count_width_lp'(els_p));
  assign empty = (count_r == '0);

  // ready_o intentionally ignores yumi_i so a full buffer never passes through
  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign empty_o = empty;
  assign count_o = count_r;

  // Pointers are a power-of-two width, so wrap-around is the natural overflow
  assign tail_prev = tail_r - ptr_width_lp'(1);

  assign enq = v_i & ~full;
  assign deq = yumi_i;

  // Merging into an entry that is leaving this cycle would lose the new bytes
  assign youngest_deq = yumi_i & (count_r == count_width_lp'(1));

  assign hit   = enq & ~empty & (addr_i == addr_mem[tail_prev]) & ~youngest_deq;
  assign alloc = enq & ~hit;

  // Head entry is presented directly from storage
  assign addr_o = addr_mem[head_r];
  assign data_o = data_mem[head_r];
  assign mask_o = mask_mem[head_r];

  // Head, tail and occupancy bookkeeping; reset discards all entries at once
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (alloc) begin
        tail_r <= tail_r + ptr_width_lp'(1);
      end
      if (deq) begin
        head_r <= head_r + ptr_width_lp'(1);
      end
      case ({alloc, deq})
        2'b10:   count_r <= count_r + count_width_lp'(1);
        2'b01:   count_r <= count_r - count_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry writes: allocate a fresh slot at tail, or merge masked lanes into the youngest
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      addr_mem[tail_r] <= addr_i;
      data_mem[tail_r] <= data_i;
      mask_mem[tail_r] <= mask_i;
    end else if (hit) begin
      for (int b = 0; b < mask_width_lp; b++) begin
        if (mask_i[b]) begin
          data_mem[tail_prev][8*b +: 8] <= data_i[8*b +: 8];
          mask_mem[tail_prev][b]        <= 1'b1;
        end
      end
    end
  end

  logic [ptr_width_lp-1:0] scan_idx;

  // Bypass scan from oldest to youngest so the youngest matching byte wins per lane
  always_comb begin
    bypass_data_o = '0;
    bypass_mask_o = '0;
    scan_idx      = '0;
    if (bypass_v_i) begin
      for (int i = 0; i < els_p; i++) begin
        scan_idx = head_r + ptr_width_lp'(i);
        if ((count_width_lp'(i) < count_r) && (addr_mem[scan_idx] == bypass_addr_i)) begin
          for (int b = 0; b < mask_width_lp; b++) begin
            if (mask_mem[scan_idx][b]) begin
              bypass_data_o[8*b +: 8] = data_mem[scan_idx][8*b +: 8];
              bypass_mask_o[b]        = 1'b1;
            end
          end
        end
      end
    end
  end

  // Consumer may only take the head when one exists
  a_yumi_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    !(yumi_i && !v_o));

  // A valid store must write at least one byte
  a_mask_nonzero: assert property (@(posedge clk_i) disable iff (reset_i)
    !(v_i && (mask_i == '0)));

endmodule
